quad_encoder_ctrl: RTL and testbench

//  Parametrised rotary-encoder front end: synchronises and debounces the

---
 rtl/enc_pkg.sv | 43 ++++
 rtl/enc_debounce.sv | 61 ++++++
 rtl/quad_encoder_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_quad_encoder_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : enc_pkg
//  Purpose  : Shared types and constants for the rotary-encoder front end:
//             quadrature state encodings, sub-step values and the default
//             debounce length for a 50 MHz system clock.
//  Revision : 1.0 - initial release
// ============================================================================
package enc_pkg;

    // Quadrature states named after the debounced {A,B} pin levels.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } quad_state_e;

    typedef logic signed [1:0] substep_t;

    localparam substep_t SUB_CW   = 2'sb01;   // +1
    localparam substep_t SUB_NONE = 2'sb00;   //  0
    localparam substep_t SUB_CCW  = 2'sb11;   // -1

    // 1 ms of stable input at 50 MHz.
    localparam int DEB_CYCLES_50M = 50000;

    // Direction of a single-bit quadrature move. Both-bit changes and
    // no-change both return SUB_NONE; the caller flags the former as an error.
    function automatic substep_t quad_substep(input quad_state_e prev,
                                              input quad_state_e cur);
        substep_t s;
        s = SUB_NONE;
        case ({prev, cur})
            {S11, S01}, {S01, S00}, {S00, S10}, {S10, S11}: s = SUB_CW;
            {S01, S11}, {S00, S01}, {S10, S00}, {S11, S10}: s = SUB_CCW;
            default:                                        s = SUB_NONE;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : enc_debounce
//  Purpose  : Two-flop synchroniser followed by a counting debouncer. The
//             output adopts the synchronised level only after DEB_CYCLES
//             consecutive cycles of disagreement; any agreeing cycle restarts
//             the count. All stages preset to RST_VAL.
//  Revision : 1.0 - initial release
// ============================================================================
module enc_debounce #(
    parameter int   DEB_CYCLES = 50000,
    parameter logic RST_VAL    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic db_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser, debounced level and disagreement counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            db_q    <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count disagreeing cycles; flip the output on the last one.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign db_o = db_q;

endmodule
`default_nettype wire

// File: rtl/quad_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : quad_encoder_ctrl
//  Purpose  : Rotary-encoder front end. Debounces A/B/button pins, decodes
//             quadrature into a signed position with detent division,
//             saturating or wrapping limits, and produces step, error,
//             press and toggle outputs (all registered).
//  Revision : 1.0 - initial release
// ============================================================================
module quad_encoder_ctrl
    import enc_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = DEB_CYCLES_50M,
    parameter int DETENT_DIV = 4,
    parameter int SATURATE   = 1
) (
    input  logic                    clk50m,
    input  logic                    rst,
    input  logic                    x_clk,
    input  logic                    x_dt,
    input  logic                    x_sw,
    input  logic                    clr,
    output logic signed [CNT_W-1:0] pos,
    output logic                    step_up,
    output logic                    step_dn,
    output logic                    quad_err,
    output logic                    btn_level,
    output logic                    btn_press,
    output logic                    btn_toggle
);

    localparam logic signed [3:0]       DIV_P   = 4'(DETENT_DIV);
    localparam logic signed [3:0]       DIV_N   = 4'sd0 - DIV_P;
    localparam logic signed [CNT_W-1:0] POS_ONE = CNT_W'(1);
    localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic a_db;
    logic b_db;
    logic sw_db;

    enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_a (
        .clk   (clk50m),
        .rst   (rst),
        .pin_i (x_clk),
        .db_o  (a_db)
    );

    enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_b (
        .clk   (clk50m),
        .rst   (rst),
        .pin_i (x_dt),
        .db_o  (b_db)
    );

    enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_sw (
        .clk   (clk50m),
        .rst   (rst),
        .pin_i (x_sw),
        .db_o  (sw_db)
    );

    // ------------------------------------------------------------------
    // Quadrature FSM: state tracks the last debounced {A,B}
    // ------------------------------------------------------------------
    quad_state_e state_q;
    quad_state_e state_d;
    quad_state_e cur_ab;
    substep_t    sub;
    logic        err_d;

    assign cur_ab = quad_state_e'({a_db, b_db});

    // State register; restarts from the idle S11 position.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            state_q <= S11;
        end else begin
            state_q <= state_d;
        end
    end

    // Follow the pins; derive the sub-step and flag double-bit jumps.
    always_comb begin
        state_d = cur_ab;
        sub     = quad_substep(state_q, cur_ab);
        err_d   = ((state_q ^ cur_ab) == 2'b11);
    end

    // ------------------------------------------------------------------
    // Position limit handling
    // ------------------------------------------------------------------
    logic signed [CNT_W-1:0] pos_q;
    logic signed [CNT_W-1:0] pos_d;
    logic signed [CNT_W-1:0] pos_inc;
    logic signed [CNT_W-1:0] pos_dec;

    generate
        if (SATURATE != 0) begin : g_sat
            assign pos_inc = (pos_q == POS_MAX) ? pos_q : pos_q + POS_ONE;
            assign pos_dec = (pos_q == POS_MIN) ? pos_q : pos_q - POS_ONE;
        end else begin : g_wrap
            assign pos_inc = pos_q + POS_ONE;
            assign pos_dec = pos_q - POS_ONE;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Detent accumulator, position and button next-state
    // ------------------------------------------------------------------
    logic signed [2:0] acc_q;
    logic signed [2:0] acc_d;
    logic signed [3:0] acc_sum;
    logic              step_up_q;
    logic              step_up_d;
    logic              step_dn_q;
    logic              step_dn_d;
    logic              err_q;
    logic              lvl_q;
    logic              lvl_d;
    logic              press_q;
    logic              press_d;
    logic              tog_q;
    logic              tog_d;

    // Accumulate sub-steps; a full detent emits a step and moves pos.
    // clr zeroes pos and accumulator but lets the step pulse through.
    always_comb begin
        acc_sum   = {acc_q[2], acc_q} + {{2{sub[1]}}, sub};
        step_up_d = (acc_sum == DIV_P);
        step_dn_d = (acc_sum == DIV_N);
        acc_d     = acc_sum[2:0];
        pos_d     = pos_q;
        if (step_up_d) begin
            acc_d = '0;
            pos_d = pos_inc;
        end else if (step_dn_d) begin
            acc_d = '0;
            pos_d = pos_dec;
        end
        if (clr) begin
            acc_d = '0;
            pos_d = '0;
        end
        lvl_d   = ~sw_db;
        press_d = ~sw_db & ~lvl_q;
        tog_d   = tog_q ^ press_d;
    end

    // Output and datapath registers.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            acc_q     <= '0;
            pos_q     <= '0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            err_q     <= 1'b0;
            lvl_q     <= 1'b0;
            press_q   <= 1'b0;
            tog_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            pos_q     <= pos_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            err_q     <= err_d;
            lvl_q     <= lvl_d;
            press_q   <= press_d;
            tog_q     <= tog_d;
        end
    end

    assign pos        = pos_q;
    assign step_up    = step_up_q;
    assign step_dn    = step_dn_q;
    assign quad_err   = err_q;
    assign btn_level  = lvl_q;
    assign btn_press  = press_q;
    assign btn_toggle = tog_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quad_encoder_ctrl
//  Purpose  : Self-checking bench for quad_encoder_ctrl with DEB_CYCLES=4,
//             CNT_W=4. A saturating and a wrapping instance share stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_ctrl;

    logic clk;
    logic rst;
    logic x_a;
    logic x_b;
    logic x_sw;
    logic clr;

    logic signed [3:0] pos_s, pos_w;
    logic up_s, dn_s, err_s, lvl_s, press_s, tog_s;
    logic up_w, dn_w, err_w, lvl_w, press_w, tog_w;

    quad_encoder_ctrl #(.CNT_W(4), .DEB_CYCLES(4), .DETENT_DIV(4), .SATURATE(1)) dut_sat (
        .clk50m(clk), .rst(rst), .x_clk(x_a), .x_dt(x_b), .x_sw(x_sw), .clr(clr),
        .pos(pos_s), .step_up(up_s), .step_dn(dn_s), .quad_err(err_s),
        .btn_level(lvl_s), .btn_press(press_s), .btn_toggle(tog_s)
    );

    quad_encoder_ctrl #(.CNT_W(4), .DEB_CYCLES(4), .DETENT_DIV(4), .SATURATE(0)) dut_wrap (
        .clk50m(clk), .rst(rst), .x_clk(x_a), .x_dt(x_b), .x_sw(x_sw), .clr(clr),
        .pos(pos_w), .step_up(up_w), .step_dn(dn_w), .quad_err(err_w),
        .btn_level(lvl_w), .btn_press(press_w), .btn_toggle(tog_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled shortly after each rising edge.
    int n_up_s = 0, n_dn_s = 0, n_err_s = 0, n_press_s = 0;
    int n_up_w = 0, n_both = 0;
    always begin
        @(posedge clk);
        #1;
        if (up_s)    n_up_s++;
        if (dn_s)    n_dn_s++;
        if (err_s)   n_err_s++;
        if (press_s) n_press_s++;
        if (up_w)    n_up_w++;
        if ((up_s && dn_s) || (up_w && dn_w)) n_both++;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; holds the pins for cyc rising edges.
    task automatic drive(input logic a, input logic b, input logic sw, input int cyc);
        x_a  = a;
        x_b  = b;
        x_sw = sw;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic cw_detent();
        drive(1'b0, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b0, 1'b1, 10);
        drive(1'b1, 1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 1'b1, 10);
    endtask

    typedef struct {
        logic a;
        logic b;
        logic sw;
        int   cyc;
        int   pos_s;
        int   pos_w;
        int   ups;
        int   dns;
        int   errs;
        int   presses;
        logic lvl;
        logic tog;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    int base_s, base_w;
    int exp_s, exp_w;

    initial begin
        //           a     b     sw   cyc  pos_s pos_w up dn er pr lvl   tog
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 100, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0}; // idle
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 10,  0, 0, 0, 0, 0, 0, 1'b0, 1'b0}; // CW 01
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 10,  0, 0, 0, 0, 0, 0, 1'b0, 1'b0}; // CW 00
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 10,  0, 0, 0, 0, 0, 0, 1'b0, 1'b0}; // CW 10
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 10,  1, 1, 1, 0, 0, 0, 1'b0, 1'b0}; // CW 11 -> step
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 10,  1, 1, 1, 0, 0, 0, 1'b0, 1'b0}; // CCW 10
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 10,  1, 1, 1, 0, 0, 0, 1'b0, 1'b0}; // CCW 00
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 10,  1, 1, 1, 0, 0, 0, 1'b0, 1'b0}; // CCW 01
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 10,  0, 0, 1, 1, 0, 0, 1'b0, 1'b0}; // CCW 11 -> step
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 3,   0, 0, 1, 1, 0, 0, 1'b0, 1'b0}; // 3-cycle glitch
        vecs[10] = '{1'b1, 1'b1, 1'b1, 10,  0, 0, 1, 1, 0, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8,   0, 0, 1, 1, 0, 0, 1'b0, 1'b0}; // 8-cycle glitch
        vecs[12] = '{1'b1, 1'b1, 1'b1, 10,  0, 0, 1, 1, 0, 0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 10,  0, 0, 1, 1, 1, 0, 1'b0, 1'b0}; // 11->00 illegal
        vecs[14] = '{1'b1, 1'b1, 1'b1, 10,  0, 0, 1, 1, 2, 0, 1'b0, 1'b0}; // 00->11 illegal
        vecs[15] = '{1'b1, 1'b1, 1'b0, 20,  0, 0, 1, 1, 2, 1, 1'b1, 1'b1}; // press 1
        vecs[16] = '{1'b1, 1'b1, 1'b1, 20,  0, 0, 1, 1, 2, 1, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 20,  0, 0, 1, 1, 2, 2, 1'b1, 1'b0}; // press 2
        vecs[18] = '{1'b1, 1'b1, 1'b1, 20,  0, 0, 1, 1, 2, 2, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 20,  0, 0, 1, 1, 2, 3, 1'b1, 1'b1}; // press 3
        vecs[20] = '{1'b1, 1'b1, 1'b1, 20,  0, 0, 1, 1, 2, 3, 1'b0, 1'b1};

        rst  = 1'b1;
        clr  = 1'b0;
        x_a  = 1'b1;
        x_b  = 1'b1;
        x_sw = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_pos",    pos_s, 0);
        chk("reset_toggle", tog_s, 0);
        chk("reset_level",  lvl_s, 0);
        rst = 1'b0;

        // Table-driven phases.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sw, vecs[i].cyc);
            chk($sformatf("v%0d_pos_sat", i),  pos_s,      vecs[i].pos_s);
            chk($sformatf("v%0d_pos_wrap", i), pos_w,      vecs[i].pos_w);
            chk($sformatf("v%0d_step_up", i),  n_up_s,     vecs[i].ups);
            chk($sformatf("v%0d_step_dn", i),  n_dn_s,     vecs[i].dns);
            chk($sformatf("v%0d_quad_err", i), n_err_s,    vecs[i].errs);
            chk($sformatf("v%0d_press", i),    n_press_s,  vecs[i].presses);
            chk($sformatf("v%0d_level", i),    lvl_s,      vecs[i].lvl);
            chk($sformatf("v%0d_toggle", i),   tog_s,      vecs[i].tog);
        end

        // Ten CW detents: saturating instance clamps at 7, wrapping one rolls over.
        base_s = n_up_s;
        base_w = n_up_w;
        for (int k = 1; k <= 10; k++) begin
            cw_detent();
            exp_s = (k > 7) ? 7 : k;
            exp_w = ((k + 8) % 16) - 8;
            chk($sformatf("sat_pos_k%0d", k),  pos_s, exp_s);
            chk($sformatf("wrap_pos_k%0d", k), pos_w, exp_w);
        end
        chk("sat_step_count",  n_up_s - base_s, 10);
        chk("wrap_step_count", n_up_w - base_w, 10);

        // clr coincident with the completing step.
        drive(1'b0, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b0, 1'b1, 10);
        drive(1'b1, 1'b0, 1'b1, 10);
        x_a = 1'b1;
        x_b = 1'b1;
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_step_pulse_sat",  up_s,  1);
        chk("clr_step_pulse_wrap", up_w,  1);
        chk("clr_pos_sat",         pos_s, 0);
        chk("clr_pos_wrap",        pos_w, 0);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        chk("clr_pos_hold", pos_w, 0);

        // Reset in the middle of a detent discards the partial count.
        cw_detent();
        chk("pre_rst_pos", pos_s, 1);
        drive(1'b0, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b0, 1'b1, 10);
        drive(1'b1, 1'b0, 1'b1, 10);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pos",    pos_s, 0);
        chk("rst_toggle", tog_s, 0);
        rst = 1'b0;
        base_s = n_up_s;
        drive(1'b1, 1'b1, 1'b1, 10);
        chk("rst_no_step_idle", n_up_s - base_s, 0);
        drive(1'b0, 1'b1, 1'b1, 10);
        chk("rst_acc_cleared", n_up_s - base_s, 0);
        drive(1'b0, 1'b0, 1'b1, 10);
        drive(1'b1, 1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 1'b1, 10);
        chk("rst_resume_step", n_up_s - base_s, 1);
        chk("rst_resume_pos",  pos_s, 1);

        chk("up_dn_exclusive", n_both, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
